// File: rtl/player_tracker_if.sv
// Move request channel from the input stage plus the wall ROM read channel,
// bundled so the tracker sees one bus. The master side is the environment
// (input decoder + wall ROM); the slave side is the tracker.
interface player_tracker_if #(
  parameter int XW = 4,
  parameter int YW = 4
);
  logic          move_valid;
  logic [1:0]    move_dir;
  logic          move_ready;
  logic          wall_rd;
  logic [XW-1:0] wall_x;
  logic [YW-1:0] wall_y;
  logic          wall_data;

  modport master (
    output move_valid, move_dir, wall_data,
    input  move_ready, wall_rd, wall_x, wall_y
  );

  modport slave (
    input  move_valid, move_dir, wall_data,
    output move_ready, wall_rd, wall_x, wall_y
  );
endinterface

// File: rtl/player_tracker.sv
// Player position tracker: validates each move against the grid border and
// a registered wall ROM, keeps the player cell, and raises a sticky
// goal-reached level for the maze that is currently selected.
module player_tracker #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 12,
  parameter int XW      = 4,
  parameter int YW      = 4,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int GOAL_X  = 14,
  parameter int GOAL_Y  = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [2:0]        maze_sel,
  player_tracker_if.slave   bus,
  output logic [XW-1:0]     player_x,
  output logic [YW-1:0]     player_y,
  output logic              move_blocked,
  output logic              goal_reach1,
  output logic              goal_reach2,
  output logic              goal_reach3
);

  localparam logic [XW-1:0] ONE_X   = XW'(1);
  localparam logic [YW-1:0] ONE_Y   = YW'(1);
  localparam logic [XW-1:0] ZERO_X  = XW'(0);
  localparam logic [YW-1:0] ZERO_Y  = YW'(0);
  localparam logic [XW-1:0] MAX_X   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] MAX_Y   = YW'(GRID_H - 1);
  localparam logic [XW-1:0] START_XV = XW'(START_X);
  localparam logic [YW-1:0] START_YV = YW'(START_Y);
  localparam logic [XW-1:0] GOAL_XV  = XW'(GOAL_X);
  localparam logic [YW-1:0] GOAL_YV  = YW'(GOAL_Y);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    CHECK  = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [2:0]    sel_q_r;
  logic [2:0]    goal_r;
  logic [XW-1:0] pos_x_r, tgt_x_r, tgt_nx_s;
  logic [YW-1:0] pos_y_r, tgt_y_r, tgt_ny_s;
  logic          blocked_r;
  logic          onehot_s, sel_chg_s, active_goal_s, at_edge_s, accept_s;
  logic          move_ready_s, wall_rd_s;

  // A maze change is any difference from last cycle's select; it flushes everything.
  assign onehot_s      = (maze_sel == 3'b001) || (maze_sel == 3'b010) || (maze_sel == 3'b100);
  assign sel_chg_s     = (maze_sel != sel_q_r);
  assign active_goal_s = |(goal_r & maze_sel);
  assign accept_s      = bus.move_valid && move_ready_s;

  // Candidate target cell; the border test comes first so no coordinate ever wraps.
  always_comb begin
    tgt_nx_s  = pos_x_r;
    tgt_ny_s  = pos_y_r;
    at_edge_s = 1'b0;
    case (bus.move_dir)
      2'd0: if (pos_y_r == ZERO_Y) at_edge_s = 1'b1; else tgt_ny_s = pos_y_r - ONE_Y;
      2'd1: if (pos_y_r == MAX_Y)  at_edge_s = 1'b1; else tgt_ny_s = pos_y_r + ONE_Y;
      2'd2: if (pos_x_r == ZERO_X) at_edge_s = 1'b1; else tgt_nx_s = pos_x_r - ONE_X;
      2'd3: if (pos_x_r == MAX_X)  at_edge_s = 1'b1; else tgt_nx_s = pos_x_r + ONE_X;
      default: at_edge_s = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic; a maze change overrides every transition.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE:    if (accept_s && !at_edge_s) state_nxt_s = LOOKUP; else state_nxt_s = IDLE;
      LOOKUP:  state_nxt_s = CHECK;
      CHECK:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
    if (sel_chg_s) state_nxt_s = IDLE;
    else           state_nxt_s = state_nxt_s;
  end

  // State-decoded outputs: ready only in IDLE with a stable, valid, unfinished maze.
  always_comb begin
    move_ready_s = 1'b0;
    wall_rd_s    = 1'b0;
    case (state_r)
      IDLE:    move_ready_s = onehot_s && !active_goal_s && !sel_chg_s;
      LOOKUP:  wall_rd_s    = 1'b1;
      default: begin
        move_ready_s = 1'b0;
        wall_rd_s    = 1'b0;
      end
    endcase
  end

  // Position, target latch, goal flags and the blocked pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sel_q_r   <= 3'b000;
      pos_x_r   <= START_XV;
      pos_y_r   <= START_YV;
      tgt_x_r   <= ZERO_X;
      tgt_y_r   <= ZERO_Y;
      goal_r    <= 3'b000;
      blocked_r <= 1'b0;
    end else begin
      sel_q_r   <= maze_sel;
      blocked_r <= 1'b0;
      if (sel_chg_s) begin
        pos_x_r <= START_XV;
        pos_y_r <= START_YV;
        goal_r  <= 3'b000;
      end else if (state_r == IDLE && accept_s) begin
        if (at_edge_s) begin
          blocked_r <= 1'b1;
        end else begin
          tgt_x_r <= tgt_nx_s;
          tgt_y_r <= tgt_ny_s;
        end
      end else if (state_r == CHECK) begin
        if (bus.wall_data) begin
          blocked_r <= 1'b1;
        end else begin
          pos_x_r <= tgt_x_r;
          pos_y_r <= tgt_y_r;
          if (tgt_x_r == GOAL_XV && tgt_y_r == GOAL_YV) goal_r <= goal_r | sel_q_r;
          else                                          goal_r <= goal_r;
        end
      end else begin
        pos_x_r <= pos_x_r;
        pos_y_r <= pos_y_r;
      end
    end
  end

  assign bus.move_ready = move_ready_s;
  assign bus.wall_rd    = wall_rd_s;
  assign bus.wall_x     = tgt_x_r;
  assign bus.wall_y     = tgt_y_r;
  assign player_x       = pos_x_r;
  assign player_y       = pos_y_r;
  assign move_blocked   = blocked_r;
  assign goal_reach1    = goal_r[0];
  assign goal_reach2    = goal_r[1];
  assign goal_reach3    = goal_r[2];

endmodule

// File: tb/tb_player_tracker.sv
// Scoreboard bench for player_tracker: stimulus pushes the expected move
// outcome and wall address; a negedge monitor pops and compares whenever the
// DUT shows a wall read, a blocked pulse or a position change.
module tb_player_tracker;
  logic       clk;
  logic       rst_n;
  logic [2:0] maze_sel;
  logic [3:0] player_x, player_y;
  logic       move_blocked, goal_reach1, goal_reach2, goal_reach3;

  player_tracker_if #(.XW(4), .YW(4)) bus();

  player_tracker dut (
    .Clk(clk), .Reset(rst_n), .maze_sel(maze_sel), .bus(bus),
    .player_x(player_x), .player_y(player_y), .move_blocked(move_blocked),
    .goal_reach1(goal_reach1), .goal_reach2(goal_reach2), .goal_reach3(goal_reach3)
  );

  typedef struct packed { logic blk; logic [3:0] x; logic [3:0] y; } ev_t;
  typedef struct packed { logic [3:0] x; logic [3:0] y; } wa_t;

  ev_t scb[$];
  wa_t wq[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  logic [3:0] prev_x = 4'd1;
  logic [3:0] prev_y = 4'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wall ROM model: only cell (1,2) is a wall; one-cycle registered read.
  always @(posedge clk) bus.wall_data <= bus.wall_rd && (bus.wall_x == 4'd1) && (bus.wall_y == 4'd2);

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compares every observable event against the scoreboard queues.
  always @(negedge clk) begin
    wa_t w;
    ev_t e;
    if (bus.wall_rd === 1'b1) begin
      if (wq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_wall_rd: got (%0d,%0d) expected none", bus.wall_x, bus.wall_y);
      end else begin
        w = wq.pop_front();
        chk4("wall_x", bus.wall_x, w.x);
        chk4("wall_y", bus.wall_y, w.y);
      end
    end
    if (move_blocked === 1'b1 || player_x !== prev_x || player_y !== prev_y) begin
      if (scb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_event: got blk=%0d pos=(%0d,%0d) expected none", move_blocked, player_x, player_y);
      end else begin
        e = scb.pop_front();
        chk1("ev_blk", move_blocked, e.blk);
        chk4("ev_x", player_x, e.x);
        chk4("ev_y", player_y, e.y);
      end
    end
    prev_x = player_x;
    prev_y = player_y;
  end

  // Issue one move and check its latency profile; called at posedge+1.
  task automatic do_move(input logic [1:0] dir, input logic lk, input logic [3:0] wx, input logic [3:0] wy,
                         input logic blk, input logic [3:0] ex, input logic [3:0] ey, input logic goal_hit);
    int w;
    ev_t e;
    wa_t a;
    w = 0;
    while (bus.move_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (bus.move_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL ready_wait: got %0d expected 1", bus.move_ready);
      return;
    end
    e.blk = blk; e.x = ex; e.y = ey;
    scb.push_back(e);
    if (lk) begin
      a.x = wx; a.y = wy;
      wq.push_back(a);
    end
    bus.move_valid = 1'b1;
    bus.move_dir   = dir;
    @(posedge clk); #1;
    bus.move_valid = 1'b0;
    if (!lk) begin
      @(negedge clk);
      chk1("edge_blk_t1", move_blocked, 1'b1);
      chk1("edge_ready_t1", bus.move_ready, 1'b1);
    end else begin
      @(negedge clk);
      chk1("lk_wall_rd", bus.wall_rd, 1'b1);
      chk1("lk_ready", bus.move_ready, 1'b0);
      @(negedge clk);
      chk1("ck_wall_rd", bus.wall_rd, 1'b0);
      chk1("ck_ready", bus.move_ready, 1'b0);
      @(negedge clk);
      chk4("res_x", player_x, ex);
      chk4("res_y", player_y, ey);
      chk1("res_blk", move_blocked, blk);
      chk1("res_ready", bus.move_ready, !goal_hit);
    end
    @(posedge clk); #1;
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e;
    wa_t a;
    rst_n = 1'b0; maze_sel = 3'b000; bus.move_valid = 1'b0; bus.move_dir = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk4("rst_x", player_x, 4'd1);
    chk4("rst_y", player_y, 4'd1);
    chk1("rst_wall_rd", bus.wall_rd, 1'b0);
    chk4("rst_wall_x", bus.wall_x, 4'd0);
    chk4("rst_wall_y", bus.wall_y, 4'd0);
    chk1("rst_blk", move_blocked, 1'b0);
    chk1("rst_goal1", goal_reach1, 1'b0);
    chk1("rst_goal2", goal_reach2, 1'b0);
    chk1("rst_goal3", goal_reach3, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("sel_none_ready", bus.move_ready, 1'b0);
    @(posedge clk); #1;
    maze_sel = 3'b001;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("maze1_ready", bus.move_ready, 1'b1);
    chk4("maze1_x", player_x, 4'd1);
    chk4("maze1_y", player_y, 4'd1);
    @(posedge clk); #1;

    // Basic moves, a wall, and both border cases.
    do_move(2'd3, 1'b1, 4'd2, 4'd1, 1'b0, 4'd2, 4'd1, 1'b0);
    do_move(2'd2, 1'b1, 4'd1, 4'd1, 1'b0, 4'd1, 4'd1, 1'b0);
    do_move(2'd1, 1'b1, 4'd1, 4'd2, 1'b1, 4'd1, 4'd1, 1'b0);
    do_move(2'd2, 1'b1, 4'd0, 4'd1, 1'b0, 4'd0, 4'd1, 1'b0);
    do_move(2'd2, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 4'd1, 1'b0);
    do_move(2'd0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    do_move(2'd0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 4'd0, 1'b0);
    do_move(2'd1, 1'b1, 4'd0, 4'd1, 1'b0, 4'd0, 4'd1, 1'b0);
    do_move(2'd3, 1'b1, 4'd1, 4'd1, 1'b0, 4'd1, 4'd1, 1'b0);

    // Walk to the goal: along y=1 to x=14, then down to y=10.
    for (int i = 2; i <= 14; i++)
      do_move(2'd3, 1'b1, 4'(i), 4'd1, 1'b0, 4'(i), 4'd1, 1'b0);
    for (int j = 2; j <= 10; j++)
      do_move(2'd1, 1'b1, 4'd14, 4'(j), 1'b0, 4'd14, 4'(j), (j == 10));
    @(negedge clk);
    chk1("goal1_set", goal_reach1, 1'b1);
    chk1("goal2_clear", goal_reach2, 1'b0);
    chk1("goal3_clear", goal_reach3, 1'b0);

    // Moves after the goal must be refused.
    @(posedge clk); #1;
    bus.move_valid = 1'b1; bus.move_dir = 2'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("goal_refuse_ready", bus.move_ready, 1'b0);
    end
    @(posedge clk); #1;
    bus.move_valid = 1'b0;
    @(negedge clk);
    chk1("goal1_held", goal_reach1, 1'b1);
    chk4("goal_pos_x", player_x, 4'd14);
    chk4("goal_pos_y", player_y, 4'd10);

    // Switch to maze 2: flush back to start, flags cleared.
    @(posedge clk); #1;
    e.blk = 1'b0; e.x = 4'd1; e.y = 4'd1;
    scb.push_back(e);
    maze_sel = 3'b010;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("m2_goal1_clr", goal_reach1, 1'b0);
    chk1("m2_ready", bus.move_ready, 1'b1);
    chk4("m2_x", player_x, 4'd1);
    chk4("m2_y", player_y, 4'd1);
    @(posedge clk); #1;

    // Maze change during CHECK aborts the move.
    do_move(2'd3, 1'b1, 4'd2, 4'd1, 1'b0, 4'd2, 4'd1, 1'b0);
    a.x = 4'd3; a.y = 4'd1;
    wq.push_back(a);
    e.blk = 1'b0; e.x = 4'd1; e.y = 4'd1;
    scb.push_back(e);
    bus.move_valid = 1'b1; bus.move_dir = 2'd3;
    @(posedge clk); #1;
    bus.move_valid = 1'b0;
    @(posedge clk); #1;
    maze_sel = 3'b100;
    @(posedge clk); #1;
    @(negedge clk);
    chk4("abort_x", player_x, 4'd1);
    chk4("abort_y", player_y, 4'd1);
    chk1("abort_blk", move_blocked, 1'b0);
    chk1("abort_ready", bus.move_ready, 1'b1);
    chk1("abort_goal2", goal_reach2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("abort_no_blk", move_blocked, 1'b0);
    end
    @(posedge clk); #1;

    // Reset asserted during LOOKUP.
    do_move(2'd3, 1'b1, 4'd2, 4'd1, 1'b0, 4'd2, 4'd1, 1'b0);
    e.blk = 1'b0; e.x = 4'd1; e.y = 4'd1;
    scb.push_back(e);
    bus.move_valid = 1'b1; bus.move_dir = 2'd3;
    @(posedge clk); #1;
    bus.move_valid = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk4("rstmid_x", player_x, 4'd1);
    chk4("rstmid_y", player_y, 4'd1);
    chk1("rstmid_wall_rd", bus.wall_rd, 1'b0);
    chk1("rstmid_blk", move_blocked, 1'b0);
    chk1("rstmid_goal3", goal_reach3, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("rstmid_ready", bus.move_ready, 1'b1);
    chk1("rstmid_blk2", move_blocked, 1'b0);
    @(posedge clk); #1;
    do_move(2'd3, 1'b1, 4'd2, 4'd1, 1'b0, 4'd2, 4'd1, 1'b0);

    // Multi-hot select: no moves accepted.
    e.blk = 1'b0; e.x = 4'd1; e.y = 4'd1;
    scb.push_back(e);
    maze_sel = 3'b110;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("multihot_ready", bus.move_ready, 1'b0);
    end
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk1("scb_empty", scb.size() == 0, 1'b1);
    chk1("wq_empty", wq.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
